// File: rtl/acc_pkg.sv
// acc_pkg: accelerator-wide types, including the FPU response reorder buffer entry.
package acc_pkg;
    localparam int ACC_ROB_ENTRIES = 4;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  tag_t;
    typedef struct packed {
        data_t               result;
        fpnew_pkg::status_t  status;
        tag_t                tag;
    } fpu_resp_t;
    typedef enum logic [1:0] {
        ROB_FREE    = 2'd0,
        ROB_PENDING = 2'd1,
        ROB_DONE    = 2'd2
    } rob_state_e;
    typedef struct packed {
        rob_state_e          state;
        reg_addr_t           rd;
        data_t               result;
        fpnew_pkg::status_t  status;
    } rob_entry_t;
endpackage

// File: rtl/fpnew_pkg.sv
// fpnew_pkg: FPU status flag type shared with the accelerator response path.
package fpnew_pkg;
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;
endpackage

// File: rtl/acc_resp_rob.sv
// acc_resp_rob: reorders out-of-order FPU responses into in-order register writeback.
// Define ACC_RESP_ROB_BYPASS_EN to let a response to the head write back in the same cycle.
module acc_resp_rob
    import acc_pkg::*;
#(
    parameter int NUM_ENTRIES = ACC_ROB_ENTRIES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    input  reg_addr_t          alloc_rd_i,
    output tag_t               alloc_tag_o,
    input  logic               resp_valid_i,
    output logic               resp_ready_o,
    input  fpu_resp_t          resp_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output reg_addr_t          wb_rd_o,
    output data_t              wb_data_o,
    output fpnew_pkg::status_t fflags_o,
    input  logic               fflags_clr_i,
    output logic               err_o,
    output logic               busy_o
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam logic [IW:0] CNT_FULL = (IW+1)'(NUM_ENTRIES);

    rob_entry_t         entries [NUM_ENTRIES];
    logic [IW-1:0]      head, tail, resp_idx;
    logic [IW:0]        count;
    logic               legal, byp, alloc, retire;
    fpnew_pkg::status_t wb_status;

    assign resp_idx = resp_i.tag[IW-1:0];
    // Upper tag bits must be clear so aliases of a valid index are rejected.
    assign legal = resp_valid_i && ((resp_i.tag >> IW) == '0) &&
                   (entries[resp_idx].state == ROB_PENDING);
`ifdef ACC_RESP_ROB_BYPASS_EN
    assign byp = legal && (resp_idx == head);
`else
    assign byp = 1'b0;
`endif
    assign alloc_ready_o = count != CNT_FULL;
    assign alloc_tag_o   = tag_t'(tail);
    assign resp_ready_o  = 1'b1;
    assign alloc         = alloc_valid_i && alloc_ready_o;
    assign wb_valid_o    = (entries[head].state == ROB_DONE) || byp;
    assign retire        = wb_valid_o && wb_ready_i;
    assign wb_rd_o       = entries[head].rd;
    assign wb_data_o     = byp ? resp_i.result : entries[head].result;
    assign wb_status     = byp ? resp_i.status : entries[head].status;
    assign busy_o        = count != '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fflags_o <= '0;
            err_o    <= 1'b0;
        end else begin
            // Retire is applied last so a bypassed head goes straight to FREE.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc && tail == IW'(i)) begin
                    entries[i].state <= ROB_PENDING;
                    entries[i].rd    <= alloc_rd_i;
                end
                if (legal && resp_idx == IW'(i)) begin
                    entries[i].state  <= ROB_DONE;
                    entries[i].result <= resp_i.result;
                    entries[i].status <= resp_i.status;
                end
                if (retire && head == IW'(i)) entries[i].state <= ROB_FREE;
            end
            if (alloc) tail <= tail + IW'(1);
            if (retire) head <= head + IW'(1);
            count    <= count + (IW+1)'(alloc) - (IW+1)'(retire);
            fflags_o <= (fflags_clr_i ? '0 : fflags_o) | (retire ? wb_status : '0);
            err_o    <= err_o | (resp_valid_i && !legal);
        end
    end
endmodule
